// File: rtl/ex_seg_pkg.sv
// rtl/ex_seg_pkg.sv - shared instruction encodings, widths and classification for the EX stage
package ex_seg_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = XLEN;
  localparam int CNT_W     = $clog2(MUL_ITERS + 1);
  localparam logic [XLEN-1:0] NOP_IR = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h04;
  localparam logic [5:0] F_SRL  = 6'h06;
  localparam logic [5:0] F_SRA  = 6'h07;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALUR, CLS_ALUIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } ins_class_e;

  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;

  function automatic ins_class_e ins_class(input logic [5:0] op, input logic is_nop);
    ins_class_e c;
    c = CLS_NOP;
    if (!is_nop) begin
      case (op)
        OP_RTYPE:                         c = CLS_ALUR;
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: c = CLS_ALUIMM;
        OP_LW:                            c = CLS_LOAD;
        OP_SW:                            c = CLS_STORE;
        OP_BEQZ, OP_BNEZ:                 c = CLS_BRANCH;
        OP_J:                             c = CLS_JUMP;
        default:                          c = CLS_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic is_mult(input logic [5:0] op, input logic [5:0] func,
                                   input logic is_nop);
    return !is_nop && (op == OP_RTYPE) && (func == F_MULT);
  endfunction

endpackage

// File: rtl/ex_seg_mul_iter.sv
// rtl/ex_seg_mul_iter.sv - fixed-latency radix-2 shift-add multiplier, low XLEN bits of product
module ex_seg_mul_iter
  import ex_seg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    // The completion cycle doubles as a load slot so back-to-back MULTs lose no cycle.
    if (start && (state_q == MUL_IDLE || done)) begin
      state_d  = MUL_BUSY;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (done) begin
      state_d = MUL_IDLE;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  assign busy   = (state_q == MUL_BUSY);
  assign done   = busy && (cnt_q == CNT_W'(MUL_ITERS));
  assign result = acc_q;

endmodule

// File: rtl/ex_seg.sv
// rtl/ex_seg.sv - execute stage: negedge operand capture, ALU/branch/address mux, MULT stall
module ex_seg
  import ex_seg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  input  logic [XLEN-1:0] Imm_i,
  input  logic [XLEN-1:0] NPC_i,
  input  logic [XLEN-1:0] IR_i,
  output logic [XLEN-1:0] ALUo_Out,
  output logic [XLEN-1:0] B_Out,
  output logic [XLEN-1:0] IR_Out,
  output logic            Cond,
  output logic            Stall
);

  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, npc_q, npc_d, ir_q, ir_d;
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_result;
  logic [XLEN-1:0] alu_res;
  logic            alu_cond;
  logic [4:0]      shamt;
  logic [5:0]      op, func;
  logic            stall;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      npc_q <= '0;
      ir_q  <= NOP_IR;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      npc_q <= npc_d;
      ir_q  <= ir_d;
    end
  end

  always_comb begin
    a_d   = stall ? a_q   : A_i;
    b_d   = stall ? b_q   : B_i;
    imm_d = stall ? imm_q : Imm_i;
    npc_d = stall ? npc_q : NPC_i;
    ir_d  = stall ? ir_q  : IR_i;
  end

  // Start is decoded from the incoming word so the multiplier loads on the same edge as the latches.
  assign mul_start = !stall && is_mult(IR_i[31:26], IR_i[5:0], IR_i == NOP_IR);

  ex_seg_mul_iter u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a_i    (A_i),
    .b_i    (B_i),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  assign stall = mul_busy && !mul_done;
  assign shamt = b_q[4:0];
  assign op    = ir_q[31:26];
  assign func  = ir_q[5:0];

  always_comb begin
    alu_res  = '0;
    alu_cond = 1'b0;
    case (ins_class(op, ir_q == NOP_IR))
      CLS_ALUR: begin
        case (func)
          F_ADD:  alu_res = a_q + b_q;
          F_SUB:  alu_res = a_q - b_q;
          F_AND:  alu_res = a_q & b_q;
          F_OR:   alu_res = a_q | b_q;
          F_XOR:  alu_res = a_q ^ b_q;
          F_SLL:  alu_res = a_q << shamt;
          F_SRL:  alu_res = a_q >> shamt;
          F_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
          F_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
          F_MULT: alu_res = mul_result;
          default: alu_res = '0;
        endcase
      end
      CLS_ALUIMM: begin
        case (op)
          OP_ADDI: alu_res = a_q + imm_q;
          OP_ANDI: alu_res = a_q & {16'h0000, imm_q[15:0]};
          OP_ORI:  alu_res = a_q | {16'h0000, imm_q[15:0]};
          OP_XORI: alu_res = a_q ^ {16'h0000, imm_q[15:0]};
          default: alu_res = '0;
        endcase
      end
      CLS_LOAD, CLS_STORE: alu_res = a_q + imm_q;
      CLS_BRANCH: begin
        alu_res  = npc_q + imm_q;
        alu_cond = (op == OP_BEQZ) ? (a_q == '0) : (a_q != '0);
      end
      CLS_JUMP: begin
        alu_res  = npc_q + {{6{ir_q[25]}}, ir_q[25:0]};
        alu_cond = 1'b1;
      end
      default: begin
        alu_res  = '0;
        alu_cond = 1'b0;
      end
    endcase
  end

  always_comb begin
    ALUo_Out = stall ? '0 : alu_res;
    IR_Out   = stall ? NOP_IR : ir_q;
    Cond     = stall ? 1'b0 : alu_cond;
    B_Out    = b_q;
    Stall    = stall;
  end

endmodule

// File: tb/tb_ex_seg.sv
// tb/tb_ex_seg.sv - directed and randomized self-checking bench for ex_seg
module tb_ex_seg;

  localparam logic [31:0] NOP = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A_i, B_i, Imm_i, NPC_i, IR_i;
  logic [31:0] ALUo_Out, B_Out, IR_Out;
  logic        Cond, Stall;

  int errors = 0;
  int checks = 0;

  logic [5:0] rfuncs [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h07, 6'h2A};
  logic [5:0] iops   [9] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

  ex_seg dut (
    .clk(clk), .rst(rst), .A_i(A_i), .B_i(B_i), .Imm_i(Imm_i), .NPC_i(NPC_i), .IR_i(IR_i),
    .ALUo_Out(ALUo_Out), .B_Out(B_Out), .IR_Out(IR_Out), .Cond(Cond), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt(input logic [5:0] f);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [25:0] rest);
    return {op, rest};
  endfunction

  // Reference: returns {cond, result} straight from the instruction-set rules.
  function automatic logic [32:0] ref_ex(input logic [31:0] ir, a, b, imm, npc);
    logic [5:0]  op;
    logic [4:0]  s;
    logic [31:0] fill;
    op = ir[31:26];
    s  = b[4:0];
    fill = 32'hFFFF_FFFF;
    if (ir == NOP) return 33'd0;
    case (op)
      6'h00: case (ir[5:0])
        6'h20: return {1'b0, a + b};
        6'h22: return {1'b0, a - b};
        6'h24: return {1'b0, a & b};
        6'h25: return {1'b0, a | b};
        6'h26: return {1'b0, a ^ b};
        6'h04: return {1'b0, a << s};
        6'h06: return {1'b0, a >> s};
        6'h07: return {1'b0, (a >> s) | (a[31] ? ~(fill >> s) : 32'h0)};
        6'h2A: return {1'b0, 31'd0, (int'(a) < int'(b))};
        6'h18: return {1'b0, a * b};
        default: return 33'd0;
      endcase
      6'h08, 6'h23, 6'h2B: return {1'b0, a + imm};
      6'h0C: return {1'b0, a & (imm & 32'h0000_FFFF)};
      6'h0D: return {1'b0, a | (imm & 32'h0000_FFFF)};
      6'h0E: return {1'b0, a ^ (imm & 32'h0000_FFFF)};
      6'h04: return {a == 0, npc + imm};
      6'h05: return {a != 0, npc + imm};
      6'h02: return {1'b1, npc + {{6{ir[25]}}, ir[25:0]}};
      default: return 33'd0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ir, a, b, imm, npc);
    IR_i = ir; A_i = a; B_i = b; Imm_i = imm; NPC_i = npc;
  endtask

  // Drive at a posedge, capture at the negedge, check at the following posedge.
  task automatic issue(input string tag, input logic [31:0] ir, a, b, imm, npc);
    logic [32:0] exp;
    drive(ir, a, b, imm, npc);
    @(negedge clk);
    @(posedge clk);
    exp = ref_ex(ir, a, b, imm, npc);
    chk({tag, ".aluo"}, ALUo_Out, exp[31:0]);
    chk({tag, ".cond"}, {31'd0, Cond}, {31'd0, exp[32]});
    chk({tag, ".ir"}, IR_Out, ir);
    chk({tag, ".b"}, B_Out, b);
    chk({tag, ".stall"}, {31'd0, Stall}, 32'd0);
  endtask

  task automatic mult(input string tag, input logic [31:0] a, b);
    int good;
    good = 0;
    drive(rt(6'h18), a, b, $urandom, $urandom);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      if (Stall === 1'b1 && IR_Out === NOP && ALUo_Out === 32'd0 && Cond === 1'b0) good++;
      drive(rt(6'h20), $urandom, $urandom, $urandom, $urandom);
    end
    chk({tag, ".stall_cycles"}, good, 32);
    @(posedge clk);
    chk({tag, ".stall"}, {31'd0, Stall}, 32'd0);
    chk({tag, ".aluo"}, ALUo_Out, a * b);
    chk({tag, ".ir"}, IR_Out, rt(6'h18));
    chk({tag, ".b"}, B_Out, b);
  endtask

  initial begin
    logic [31:0] ir, a;
    int k;
    rst = 1'b0;
    drive(NOP, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    chk("reset.aluo", ALUo_Out, 32'd0);
    chk("reset.b", B_Out, 32'd0);
    chk("reset.ir", IR_Out, NOP);
    chk("reset.cond", {31'd0, Cond}, 32'd0);
    chk("reset.stall", {31'd0, Stall}, 32'd0);
    rst = 1'b1;

    issue("add", rt(6'h20), 32'd7, 32'd5, 32'd0, 32'd0);
    chk("add.value", ALUo_Out, 32'd12);
    issue("sw", it(6'h2B, 26'h0), 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0);
    chk("sw.value", ALUo_Out, 32'hFC);
    issue("beqz", it(6'h04, 26'h0), 32'd0, 32'd0, 32'd8, 32'h40);
    chk("beqz.value", ALUo_Out, 32'h48);
    chk("beqz.taken", {31'd0, Cond}, 32'd1);
    issue("sra", rt(6'h07), 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    chk("sra.value", ALUo_Out, 32'hF800_0000);
    issue("slt", rt(6'h2A), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("slt.value", ALUo_Out, 32'd1);
    issue("nop", NOP, $urandom, $urandom, $urandom, $urandom);
    issue("unk_op", it(6'h11, 26'h155), $urandom, $urandom, $urandom, $urandom);
    issue("jneg", it(6'h02, 26'h3FF_FFF0), 32'd0, 32'd0, 32'd0, 32'h1000);

    mult("mult_neg", 32'hFFFF_FFFF, 32'd3);
    mult("mult_b2b_1", 32'd6, 32'd7);
    mult("mult_b2b_2", 32'd9, 32'd9);
    issue("after_mult", rt(6'h22), 32'd10, 32'd3, 32'd0, 32'd0);
    mult("mult_zero", 32'd0, $urandom);
    mult("mult_min", 32'h8000_0000, 32'h8000_0000);
    for (int n = 0; n < 3; n++) mult("mult_rand", $urandom, $urandom);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 17);
      ir = (k < 9) ? rt(rfuncs[k]) : it(iops[k-9], 26'($urandom));
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue("rand", ir, a, $urandom, $urandom, $urandom);
    end

    drive(rt(6'h18), 32'd123, 32'd456, 32'd0, 32'd0);
    @(negedge clk);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.stall", {31'd0, Stall}, 32'd0);
    chk("rst_mid.ir", IR_Out, NOP);
    chk("rst_mid.aluo", ALUo_Out, 32'd0);
    chk("rst_mid.cond", {31'd0, Cond}, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    issue("post_rst_add", rt(6'h20), 32'd3, 32'd4, 32'd0, 32'd0);
    chk("post_rst_add.value", ALUo_Out, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
